// File: rtl/writeback_stage_if.sv
// MEM/WB bus: memory-stage capture fields, pipeline controls, decode forwarding
// probes and the register-file write port.
interface writeback_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
);
    logic                  stall;
    logic                  flush;
    logic                  mem_valid;
    logic                  mem_regwrite;
    logic                  mem_memtoreg;
    logic                  mem_regdst;
    logic [ADDR_WIDTH-1:0] mem_wreg_rd;
    logic [ADDR_WIDTH-1:0] mem_wreg_rt;
    logic [DATA_WIDTH-1:0] mem_alu_result;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic [ADDR_WIDTH-1:0] rs_address;
    logic [ADDR_WIDTH-1:0] rt_address;

    logic                  regwrite;
    logic                  memtoreg;
    logic [ADDR_WIDTH-1:0] wreg_address;
    logic [DATA_WIDTH-1:0] memory_data;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  fwd_rs_hit;
    logic                  fwd_rt_hit;
    logic                  wb_valid;
    logic [CNT_WIDTH-1:0]  retire_count;

    modport master (
        output stall, flush, mem_valid, mem_regwrite, mem_memtoreg, mem_regdst,
               mem_wreg_rd, mem_wreg_rt, mem_alu_result, mem_read_data,
               rs_address, rt_address,
        input  regwrite, memtoreg, wreg_address, memory_data, alu_result,
               write_data, fwd_rs_hit, fwd_rt_hit, wb_valid, retire_count
    );

    modport slave (
        input  stall, flush, mem_valid, mem_regwrite, mem_memtoreg, mem_regdst,
               mem_wreg_rd, mem_wreg_rt, mem_alu_result, mem_read_data,
               rs_address, rt_address,
        output regwrite, memtoreg, wreg_address, memory_data, alu_result,
               write_data, fwd_rs_hit, fwd_rt_hit, wb_valid, retire_count
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with writeback control, same-cycle forwarding
// compares for decode, and a retired-instruction counter.
module writeback_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic             clock,
    input  logic             reset,
    writeback_stage_if.slave wb
);
    logic                  wb_valid_q,    wb_valid_d;
    logic                  wb_regwrite_q, wb_regwrite_d;
    logic                  wb_memtoreg_q, wb_memtoreg_d;
    logic [ADDR_WIDTH-1:0] dest_q,        dest_d;
    logic [DATA_WIDTH-1:0] mem_data_q,    mem_data_d;
    logic [DATA_WIDTH-1:0] alu_q,         alu_d;
    logic [CNT_WIDTH-1:0]  retire_q,      retire_d;
    logic                  retire_evt;
    logic                  wr_active;

    always_comb begin
        wb_valid_d    = wb_valid_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_memtoreg_d = wb_memtoreg_q;
        dest_d        = dest_q;
        mem_data_d    = mem_data_q;
        alu_d         = alu_q;
        if (wb.flush) begin
            wb_valid_d    = 1'b0;
            wb_regwrite_d = 1'b0;
            wb_memtoreg_d = 1'b0;
            dest_d        = '0;
            mem_data_d    = '0;
            alu_d         = '0;
        end else if (!wb.stall) begin
            wb_valid_d    = wb.mem_valid;
            wb_regwrite_d = wb.mem_regwrite;
            wb_memtoreg_d = wb.mem_memtoreg;
            // Destination is resolved here so WB never needs the regdst bit.
            dest_d        = wb.mem_regdst ? wb.mem_wreg_rd : wb.mem_wreg_rt;
            mem_data_d    = wb.mem_read_data;
            alu_d         = wb.mem_alu_result;
        end
        // An instruction retires when it leaves WB, whether by advance or flush.
        retire_evt = wb_valid_q & (~wb.stall | wb.flush);
        retire_d   = retire_q + {{(CNT_WIDTH-1){1'b0}}, retire_evt};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            dest_q        <= '0;
            mem_data_q    <= '0;
            alu_q         <= '0;
            retire_q      <= '0;
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            dest_q        <= dest_d;
            mem_data_q    <= mem_data_d;
            alu_q         <= alu_d;
            retire_q      <= retire_d;
        end
    end

    // Register 0 is hardwired; suppressing it here also keeps forwarding off it.
    assign wr_active       = wb_valid_q & wb_regwrite_q & (dest_q != '0);
    assign wb.regwrite     = wr_active;
    assign wb.memtoreg     = wb_memtoreg_q;
    assign wb.wreg_address = dest_q;
    assign wb.memory_data  = mem_data_q;
    assign wb.alu_result   = alu_q;
    assign wb.write_data   = wb_memtoreg_q ? mem_data_q : alu_q;
    assign wb.fwd_rs_hit   = wr_active & (wb.rs_address == dest_q);
    assign wb.fwd_rt_hit   = wr_active & (wb.rt_address == dest_q);
    assign wb.wb_valid     = wb_valid_q;
    assign wb.retire_count = retire_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage; a 3-bit-counter copy shares the
// stimulus so counter wrap is observed within a short run.
module tb_writeback_stage;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    writeback_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) wb ();
    writeback_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(3))  wbs ();

    writeback_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .wb(wb.slave));
    writeback_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(3)) dut_small (
        .clock(clock), .reset(reset), .wb(wbs.slave));

    assign wbs.stall          = wb.stall;
    assign wbs.flush          = wb.flush;
    assign wbs.mem_valid      = wb.mem_valid;
    assign wbs.mem_regwrite   = wb.mem_regwrite;
    assign wbs.mem_memtoreg   = wb.mem_memtoreg;
    assign wbs.mem_regdst     = wb.mem_regdst;
    assign wbs.mem_wreg_rd    = wb.mem_wreg_rd;
    assign wbs.mem_wreg_rt    = wb.mem_wreg_rt;
    assign wbs.mem_alu_result = wb.mem_alu_result;
    assign wbs.mem_read_data  = wb.mem_read_data;
    assign wbs.rs_address     = wb.rs_address;
    assign wbs.rt_address     = wb.rt_address;

    typedef struct {
        logic        v;
        logic        rw;
        logic        m2r;
        logic [4:0]  a;
        logic [31:0] md;
        logic [31:0] alu;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic [31:0] cnt_model;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t bubble();
        exp_t b;
        b.v = 1'b0; b.rw = 1'b0; b.m2r = 1'b0; b.a = '0;
        b.md = '0; b.alu = '0; b.cnt = '0;
        return b;
    endfunction

    task automatic compare_out();
        exp_t e;
        logic erw;
        if (exp_q.size() == 0) begin
            chk_eq("queue_empty", 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        erw = e.v & e.rw & (e.a != 5'd0);
        chk_eq("wb_valid",     {63'd0, wb.wb_valid},     {63'd0, e.v});
        chk_eq("regwrite",     {63'd0, wb.regwrite},     {63'd0, erw});
        chk_eq("memtoreg",     {63'd0, wb.memtoreg},     {63'd0, e.m2r});
        chk_eq("wreg_address", {59'd0, wb.wreg_address}, {59'd0, e.a});
        chk_eq("memory_data",  {32'd0, wb.memory_data},  {32'd0, e.md});
        chk_eq("alu_result",   {32'd0, wb.alu_result},   {32'd0, e.alu});
        chk_eq("write_data",   {32'd0, wb.write_data},   {32'd0, e.m2r ? e.md : e.alu});
        chk_eq("fwd_rs_hit",   {63'd0, wb.fwd_rs_hit},   {63'd0, erw & (wb.rs_address == e.a)});
        chk_eq("fwd_rt_hit",   {63'd0, wb.fwd_rt_hit},   {63'd0, erw & (wb.rt_address == e.a)});
        chk_eq("retire_count", {32'd0, wb.retire_count}, {32'd0, e.cnt});
        chk_eq("retire_wrap3", {61'd0, wbs.retire_count}, {61'd0, e.cnt[2:0]});
    endtask

    task automatic step(input logic v, input logic rw, input logic m2r, input logic rdst,
                        input logic [4:0] rd, input logic [4:0] rt,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic stl, input logic fl,
                        input logic [4:0] rs_a, input logic [4:0] rt_a);
        exp_t nx;
        @(negedge clock);
        wb.mem_valid = v; wb.mem_regwrite = rw; wb.mem_memtoreg = m2r; wb.mem_regdst = rdst;
        wb.mem_wreg_rd = rd; wb.mem_wreg_rt = rt;
        wb.mem_alu_result = alu; wb.mem_read_data = rdata;
        wb.stall = stl; wb.flush = fl;
        wb.rs_address = rs_a; wb.rt_address = rt_a;
        if (fl) begin
            if (cur.v) cnt_model = cnt_model + 32'd1;
            nx = bubble();
        end else if (stl) begin
            nx = cur;
        end else begin
            if (cur.v) cnt_model = cnt_model + 32'd1;
            nx.v = v; nx.rw = rw; nx.m2r = m2r; nx.a = rdst ? rd : rt;
            nx.md = rdata; nx.alu = alu;
        end
        nx.cnt = cnt_model;
        cur = nx;
        exp_q.push_back(nx);
        @(posedge clock);
        #1;
        compare_out();
    endtask

    initial begin
        cur = bubble();
        cnt_model = '0;
        wb.mem_valid = 0; wb.mem_regwrite = 0; wb.mem_memtoreg = 0; wb.mem_regdst = 0;
        wb.mem_wreg_rd = '0; wb.mem_wreg_rt = '0; wb.mem_alu_result = '0; wb.mem_read_data = '0;
        wb.stall = 0; wb.flush = 0; wb.rs_address = '0; wb.rt_address = '0;

        #12;
        chk_eq("rst_regwrite",   {63'd0, wb.regwrite},     64'd0);
        chk_eq("rst_wb_valid",   {63'd0, wb.wb_valid},     64'd0);
        chk_eq("rst_write_data", {32'd0, wb.write_data},   64'd0);
        chk_eq("rst_fwd_rs",     {63'd0, wb.fwd_rs_hit},   64'd0);
        chk_eq("rst_retire",     {32'd0, wb.retire_count}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // ALU op to rd=8, then load to rt=9 (ALU op retires on this edge)
        step(1, 1, 0, 1, 5'd8, 5'd2, 32'h0000_1234, 32'h5555_0000, 0, 0, 5'd8, 5'd1);
        step(1, 1, 1, 0, 5'd4, 5'd9, 32'h0000_0040, 32'hDEAD_BEEF, 0, 0, 5'd1, 5'd9);
        // write to register 0 is suppressed but still retires
        step(1, 1, 0, 1, 5'd0, 5'd7, 32'h0000_0077, 32'h0, 0, 0, 5'd0, 5'd0);
        // forwarding on reg 5, then same dest without regwrite
        step(1, 1, 0, 1, 5'd5, 5'd1, 32'h0000_0555, 32'h0, 0, 0, 5'd5, 5'd6);
        step(1, 0, 0, 1, 5'd5, 5'd1, 32'h0000_0666, 32'h0, 0, 0, 5'd5, 5'd6);
        // write reg 3 then hold 3 cycles with changing inputs
        step(1, 1, 0, 1, 5'd3, 5'd1, 32'h0000_0333, 32'h0, 0, 0, 5'd3, 5'd0);
        for (int i = 0; i < 3; i++)
            step(1, 1, 1, 0, 5'd10, 5'd11 + 5'(i), 32'hAAAA_0000 + i, 32'hBBBB_0000, 1, 0, 5'd3, 5'd3);
        // stall and flush together: flush wins, WB instruction retires
        step(1, 1, 0, 1, 5'd12, 5'd1, 32'h0000_0C0C, 32'h0, 1, 1, 5'd12, 5'd0);
        // bubble captured, never writes or counts
        step(0, 1, 0, 1, 5'd13, 5'd1, 32'h0000_0D0D, 32'h0, 0, 0, 5'd13, 5'd0);
        step(0, 1, 0, 1, 5'd13, 5'd1, 32'h0000_0D0D, 32'h0, 0, 0, 5'd13, 5'd0);

        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        // async reset between edges while a write is pending
        step(1, 1, 0, 1, 5'd17, 5'd1, 32'h0000_1717, 32'h0, 0, 0, 5'd17, 5'd0);
        step(1, 1, 0, 1, 5'd18, 5'd1, 32'h0000_1818, 32'h0, 1, 0, 5'd17, 5'd0);
        #2;
        reset = 1'b0;
        #1;
        chk_eq("arst_regwrite", {63'd0, wb.regwrite},      64'd0);
        chk_eq("arst_retire",   {32'd0, wb.retire_count},  64'd0);
        chk_eq("arst_wb_valid", {63'd0, wb.wb_valid},      64'd0);
        chk_eq("arst_retire3",  {61'd0, wbs.retire_count}, 64'd0);
        cur = bubble();
        cnt_model = '0;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 10; i++)
            step(1, 1, 0, 1, 5'(i + 1), 5'd0, 32'h100 + i, 32'h0, 0, 0, 5'(i), 5'(i + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
